fifo_8_reader: RTL and testbench



---
 rtl/fifo_reader_pkg.sv | 11 +
 rtl/fifo_8_reader_if.sv | 26 ++
 rtl/fifo_reader_obuf.sv | 48 ++++
 rtl/fifo_8_reader.sv | 82 ++++++++
 tb/tb_fifo_8_reader.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and default sizes for the FIFO_8 read-side controller.
package fifo_reader_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_OUT_DEPTH  = 3;

    typedef logic [3:0]            occ_t;
    typedef logic [DEF_DATA_W-1:0] data_t;

endpackage

// File: rtl/fifo_8_reader_if.sv
// FIFO_8 read-side and downstream stream signals of fifo_8_reader.
interface fifo_8_reader_if #(
    parameter int DATA_W = fifo_reader_pkg::DEF_DATA_W
);
    logic                  fifo_wen;
    logic                  fifo_ren;
    logic [DATA_W-1:0]     fifo_dout;
    logic                  fifo_error;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_W-1:0]     m_data;
    fifo_reader_pkg::occ_t occupancy;
    logic                  wr_drop;
    logic                  sync_err;

    modport master (
        input  fifo_wen, fifo_dout, fifo_error, m_ready,
        output fifo_ren, m_valid, m_data, occupancy, wr_drop, sync_err
    );

    modport slave (
        output fifo_wen, fifo_dout, fifo_error, m_ready,
        input  fifo_ren, m_valid, m_data, occupancy, wr_drop, sync_err
    );

endinterface

// File: rtl/fifo_reader_obuf.sv
// Small circular output buffer: push at tail, pop from head, occupancy count.
module fifo_reader_obuf #(
    parameter  int DEPTH = 3,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: storage is not reset; count gates every read of it, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_8_reader.sv
// Read-side controller for FIFO_8: occupancy mirror, read policy, error check.
// Optional macro FIFO_READER_YIELD_EN: reads yield to producer writes.
module fifo_8_reader
    import fifo_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int OUT_DEPTH  = DEF_OUT_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_8_reader_if.master bus
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    occ_t             occ;
    logic             rd_pend;
    logic             exp_err;
    logic             wr_drop_q;
    logic             sync_err_q;
    logic [CNT_W-1:0] buf_cnt;
    logic [CNT_W:0]   committed;
    logic             ren;
    logic             m_valid;
    logic             pop;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        committed = {1'b0, buf_cnt} + (CNT_W + 1)'(rd_pend);
        ren       = (occ != '0) && (committed < (CNT_W + 1)'(OUT_DEPTH));
`ifdef FIFO_READER_YIELD_EN
        ren       = ren && !bus.fifo_wen;
`endif
    end

    // FIFO_8 gives ren priority, so a coincident write is lost unless reads yield.
    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ        <= '0;
            rd_pend    <= 1'b0;
            exp_err    <= 1'b0;
            wr_drop_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            rd_pend   <= ren;
            wr_drop_q <= ren && bus.fifo_wen;
            exp_err   <= 1'b0;
            if (ren) begin
                occ <= occ - occ_t'(1);
            end else if (bus.fifo_wen) begin
                if (occ < occ_t'(FIFO_DEPTH)) occ     <= occ + occ_t'(1);
                else                          exp_err <= 1'b1;
            end
            if (bus.fifo_error && !exp_err) sync_err_q <= 1'b1;
        end
    end

    assign m_valid = (buf_cnt != '0);
    assign pop     = m_valid && bus.m_ready;

    fifo_reader_obuf #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (DATA_W)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (bus.fifo_dout),
        .pop       (pop),
        .head      (bus.m_data),
        .count     (buf_cnt)
    );

    assign bus.fifo_ren  = ren;
    assign bus.m_valid   = m_valid;
    assign bus.occupancy = occ;
    assign bus.wr_drop   = wr_drop_q;
    assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_fifo_8_reader.sv
// Bench for fifo_8_reader: FIFO_8 model, stream scoreboard, directed scenarios.
`timescale 1ns/1ps
module tb_fifo_8_reader;

    localparam int FIFO_DEPTH = 8;
    localparam int OUT_DEPTH  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wen = 1'b0;
    logic [7:0] din = 8'h00;
    logic       m_ready = 1'b0;
    logic       force_err = 1'b0;
    logic       model_err = 1'b0;
    logic [7:0] fifo_dout_m = 8'h00;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_8_reader_if bus ();

    assign bus.fifo_wen   = wen;
    assign bus.m_ready    = m_ready;
    assign bus.fifo_dout  = fifo_dout_m;
    assign bus.fifo_error = model_err | force_err;

    fifo_8_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment: FIFO_8 contents, words read but not yet consumed, buffer fill.
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic [7:0] pop_log[$];
    bit         rd_prev;
    int         buf_exp;
    bit         m_pop;
    bit         drop_exp = 1'b0;
    bit         sync_exp = 1'b0;
    bit         full_err_prev = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            fq.delete();
            exp_q.delete();
            rd_prev       = 1'b0;
            buf_exp       = 0;
            drop_exp      <= 1'b0;
            sync_exp      <= 1'b0;
            full_err_prev <= 1'b0;
            model_err     <= 1'b0;
            fifo_dout_m   <= 8'h00;
        end else begin
            m_pop = (buf_exp > 0) && m_ready;
            if (m_pop && exp_q.size() > 0) void'(exp_q.pop_front());
            buf_exp = buf_exp + int'(rd_prev) - int'(m_pop);
            model_err     <= 1'b0;
            full_err_prev <= 1'b0;
            if (bus.fifo_ren) begin
                if (fq.size() == 0) begin
                    model_err <= 1'b1;
                end else begin
                    fifo_dout_m <= fq[0];
                    exp_q.push_back(fq[0]);
                    void'(fq.pop_front());
                end
            end else if (wen) begin
                if (fq.size() == FIFO_DEPTH) begin
                    model_err     <= 1'b1;
                    full_err_prev <= 1'b1;
                end else begin
                    fq.push_back(din);
                end
            end
            drop_exp <= bus.fifo_ren && wen;
            if (bus.fifo_error && !full_err_prev) sync_exp <= 1'b1;
            rd_prev = bus.fifo_ren;
        end
    end

    // Per-cycle comparison against the environment, mid-cycle.
    bit         hold_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    bit         ren_exp;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            ren_exp = (fq.size() > 0) && ((buf_exp + int'(rd_prev)) < OUT_DEPTH);
`ifdef FIFO_READER_YIELD_EN
            ren_exp = ren_exp && !wen;
`endif
            check("occupancy", bus.occupancy, fq.size());
            check("m_valid", bus.m_valid, buf_exp > 0);
            check("fifo_ren", bus.fifo_ren, ren_exp);
            check("wr_drop", bus.wr_drop, drop_exp);
            check("sync_err", bus.sync_err, sync_exp);
            if (hold_prev) check("m_data_hold", bus.m_data, data_prev);
            if (bus.m_valid && bus.m_ready) begin
                check("stream_data", bus.m_data,
                      (exp_q.size() > 0) ? {24'd0, exp_q[0]} : 32'hDEAD_BEEF);
                pop_log.push_back(bus.m_data);
            end
            hold_prev = bus.m_valid && !bus.m_ready;
            data_prev = bus.m_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic write_spaced(input logic [7:0] d);
        wen = 1'b1;
        din = d;
        tick();
        wen = 1'b0;
        tick();
    endtask

    task automatic check_log(input string name, input logic [7:0] exp_vals[$]);
        check({name, "_len"}, pop_log.size(), exp_vals.size());
        foreach (exp_vals[i])
            check($sformatf("%s_%0d", name, i),
                  (i < pop_log.size()) ? {24'd0, pop_log[i]} : 32'hDEAD_BEEF,
                  {24'd0, exp_vals[i]});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_occ"},      bus.occupancy, 0);
        check({tag, "_m_valid"},  bus.m_valid,   0);
        check({tag, "_m_data"},   bus.m_data,    0);
        check({tag, "_fifo_ren"}, bus.fifo_ren,  0);
        check({tag, "_wr_drop"},  bus.wr_drop,   0);
        check({tag, "_sync_err"}, bus.sync_err,  0);
    endtask

    logic [7:0] exp_t2[$];

    initial begin
        tick(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Spaced writes with the consumer ready: order and first-word latency.
        m_ready = 1'b1;
        pop_log.delete();
        wen = 1'b1; din = 8'h11;
        tick();
        wen = 1'b0;
        check("lat_after_write_edge", bus.m_valid, 0);
        tick();
        check("lat_after_ren_edge", bus.m_valid, 0);
        wen = 1'b1; din = 8'h22;
        tick();
        check("lat_after_capture_edge", bus.m_valid, 1);
        check("lat_first_data", bus.m_data, 8'h11);
        wen = 1'b0;
        tick();
        wen = 1'b1; din = 8'h33;
        tick();
        wen = 1'b0;
        tick(6);
        check_log("t1", '{8'h11, 8'h22, 8'h33});
        check("t1_occ_empty", bus.occupancy, 0);

        // Fill the buffer, then saturate the FIFO with the consumer stalled.
        m_ready = 1'b0;
        pop_log.delete();
        write_spaced(8'hA1);
        write_spaced(8'hA2);
        write_spaced(8'hA3);
        tick(3);
        check("t2_buf_full_valid", bus.m_valid, 1);
        check("t2_buf_full_occ", bus.occupancy, 0);
        for (int i = 0; i < 10; i++) begin
            wen = 1'b1;
            din = 8'hB0 + 8'(i);
            tick();
        end
        wen = 1'b0;
        tick(2);
        check("t2_occ_saturated", bus.occupancy, 8);
        check("t2_no_sync_err", bus.sync_err, 0);
        check("t3_no_ren_buf_full", bus.fifo_ren, 0);
        check("t3_m_data_held", bus.m_data, 8'hA1);

        // Release the consumer: one word per cycle until drained.
        m_ready = 1'b1;
        tick(11);
        exp_t2 = '{8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 8; i++) exp_t2.push_back(8'hB0 + 8'(i));
        check_log("t3", exp_t2);
        check("t3_drained_valid", bus.m_valid, 0);
        check("t3_drained_occ", bus.occupancy, 0);

        // Write coinciding with a read.
        pop_log.delete();
        wen = 1'b1; din = 8'hC1;
        tick();
        din = 8'hC2;
`ifdef FIFO_READER_YIELD_EN
        check("t4_ren_yields", bus.fifo_ren, 0);
`else
        check("t4_ren_wins", bus.fifo_ren, 1);
`endif
        tick();
        wen = 1'b0;
`ifdef FIFO_READER_YIELD_EN
        check("t4_wr_drop", bus.wr_drop, 0);
        check("t4_occ", bus.occupancy, 2);
`else
        check("t4_wr_drop", bus.wr_drop, 1);
        check("t4_occ", bus.occupancy, 0);
`endif
        tick();
        check("t4_wr_drop_one_cycle", bus.wr_drop, 0);
        tick(6);
`ifdef FIFO_READER_YIELD_EN
        check_log("t4", '{8'hC1, 8'hC2});
`else
        check_log("t4", '{8'hC1});
`endif

        // Unexpected error while idle: sticky until reset.
        force_err = 1'b1;
        tick();
        force_err = 1'b0;
        check("t5_sync_err_set", bus.sync_err, 1);
        tick(5);
        check("t5_sync_err_sticky", bus.sync_err, 1);
        rst_n = 1'b0;
        #1;
        check("t5_sync_err_cleared", bus.sync_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a burst with occupancy 5.
        m_ready = 1'b0;
        write_spaced(8'hD1);
        write_spaced(8'hD2);
        write_spaced(8'hD3);
        tick(3);
        for (int i = 0; i < 5; i++) begin
            wen = 1'b1;
            din = 8'hE0 + 8'(i);
            tick();
        end
        check("t6_occ_before_reset", bus.occupancy, 5);
        din = 8'hE5;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        wen = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        m_ready = 1'b1;
        pop_log.delete();
        write_spaced(8'hF1);
        write_spaced(8'hF2);
        tick(5);
        check_log("t6_after", '{8'hF1, 8'hF2});
        check("t6_occ_final", bus.occupancy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
